// File: rtl/sr_pkg.sv
// Shared FSM type and frame-length helpers for the PISO transmitter.
// Defining SR_PISO_PARITY_EN appends one even-parity bit to every frame.
package sr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits on the wire per word: data bits plus the optional parity bit.
    function automatic int frame_len(input int width);
`ifdef SR_PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(frame_len(width));
    endfunction

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/sr_piso_ctrl.sv
// Frame sequencer: IDLE/SHIFT FSM, remaining-bit counter and load handshake.
// Frame length follows SR_PISO_PARITY_EN through sr_pkg::frame_len.
module sr_piso_ctrl
    import sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_valid,
    output logic load_ready,
    output logic load_fire,
    output logic sout_valid,
    output logic done
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             last_bit;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign last_bit = (state == SHIFT) && (cnt == '0);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_ready = 1'b0;
        load_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_fire  = 1'b1;
                    state_next = SHIFT;
                    cnt_next   = CNT_LAST;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    // The last bit is going out: a new word may follow with no gap.
                    load_ready = 1'b1;
                    if (load_valid) begin
                        load_fire = 1'b1;
                        cnt_next  = CNT_LAST;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sout_valid = (state == SHIFT);
    assign done       = last_bit;

endmodule

// File: rtl/sr_piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, zero-gap streaming.
// Build option SR_PISO_PARITY_EN adds a trailing even-parity bit.
module sr_piso_tx
    import sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    logic [WIDTH-1:0] shreg;
    logic             load_fire;

    sr_piso_ctrl #(
        .WIDTH(WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_fire (load_fire),
        .sout_valid(sout_valid),
        .done      (done)
    );

    // Zero fill means the register is empty again by the end of every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load_fire) begin
            shreg <= pin;
        end else if (sout_valid) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef SR_PISO_PARITY_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (load_fire) begin
            parity <= ^pin;
        end
    end

    // The parity bit occupies the final frame slot, the one flagged by done.
    assign sout = sout_valid & (done ? parity : shreg[WIDTH-1]);
`else
    assign sout = sout_valid & shreg[WIDTH-1];
`endif

endmodule

// File: tb/tb_sr_piso_tx.sv
// Self-checking bench for sr_piso_tx (WIDTH=4 and WIDTH=8 instances) against a
// queue-of-pending-bits reference model; follows SR_PISO_PARITY_EN if defined.
module tb_sr_piso_tx;

`ifdef SR_PISO_PARITY_EN
    localparam int F4 = 5;
    localparam int F8 = 9;
    localparam logic [15:0] S_1011 = 16'b10111;
    localparam logic [15:0] S_B2B  = 16'b10111_01100;
    localparam logic [15:0] S_0001 = 16'b00011;
    localparam logic [15:0] S_A5   = 16'b1010_0101_0;
`else
    localparam int F4 = 4;
    localparam int F8 = 8;
    localparam logic [15:0] S_1011 = 16'b1011;
    localparam logic [15:0] S_B2B  = 16'b1011_0110;
    localparam logic [15:0] S_0001 = 16'b0001;
    localparam logic [15:0] S_A5   = 16'hA5;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pin4;
    logic       lv4, rdy4, so4, sv4, dn4;
    logic [7:0] pin8;
    logic       lv8, rdy8, so8, sv8, dn8;

    int errors = 0;
    int checks = 0;

    // Reference model: bits still owed on the wire, head = bit on sout this cycle.
    bit q4[$];
    bit q8[$];

    always #5 clk = ~clk;

    sr_piso_tx #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .pin(pin4), .load_valid(lv4),
        .load_ready(rdy4), .sout(so4), .sout_valid(sv4), .done(dn4)
    );

    sr_piso_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .pin(pin8), .load_valid(lv8),
        .load_ready(rdy8), .sout(so8), .sout_valid(sv8), .done(dn8)
    );

    // Expected {sout_valid, sout, done, load_ready}: busy while more than one bit is owed.
    function automatic logic [3:0] exp4();
        return {q4.size() > 0, (q4.size() > 0) ? q4[0] : 1'b0, q4.size() == 1, q4.size() <= 1};
    endfunction

    function automatic logic [3:0] exp8();
        return {q8.size() > 0, (q8.size() > 0) ? q8[0] : 1'b0, q8.size() == 1, q8.size() <= 1};
    endfunction

    // Apply inputs for one cycle, advance the model across the edge, settle 1 time unit.
    task automatic drive(input logic r, input logic l4, input logic [3:0] p4,
                         input logic l8, input logic [7:0] p8);
        bit rd4, rd8;
        rst = r; lv4 = l4; pin4 = p4; lv8 = l8; pin8 = p8;
        @(posedge clk);
        if (r) begin
            q4.delete();
            q8.delete();
        end else begin
            rd4 = (q4.size() <= 1);
            rd8 = (q8.size() <= 1);
            if (q4.size() > 0) void'(q4.pop_front());
            if (q8.size() > 0) void'(q8.pop_front());
            if (l4 && rd4) begin
                for (int i = 3; i >= 0; i--) q4.push_back(p4[i]);
`ifdef SR_PISO_PARITY_EN
                q4.push_back(^p4);
`endif
            end
            if (l8 && rd8) begin
                for (int i = 7; i >= 0; i--) q8.push_back(p8[i]);
`ifdef SR_PISO_PARITY_EN
                q8.push_back(^p8);
`endif
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) drive(1'b1, 1'b1, 4'b1011, 1'b1, 8'hFF);
        checks++;
        if ({sv4, so4, dn4, rdy4} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_w4: got %b want 0001", {sv4, so4, dn4, rdy4});
        end
        checks++;
        if ({sv8, so8, dn8, rdy8} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_w8: got %b want 0001", {sv8, so8, dn8, rdy8});
        end
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00);
        checks++;
        if ({sv4, so4, dn4, rdy4} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0001", {sv4, so4, dn4, rdy4});
        end
    endtask

    task automatic test_single();
        logic [15:0] s = '0;
        int n = 0, done_cyc = -1;
        for (int i = 0; i < F4 + 4; i++) begin
            drive(1'b0, i == 0, 4'b1011, 1'b0, 8'h00);
            checks++;
            if ({sv4, so4, dn4, rdy4} !== exp4()) begin
                errors++;
                $display("FAIL single cyc%0d: got %b want %b", i + 1, {sv4, so4, dn4, rdy4}, exp4());
            end
            if (sv4) begin s = {s[14:0], so4}; n++; end
            if (dn4) done_cyc = i + 1;
        end
        checks++;
        if (s !== S_1011 || n != F4 || done_cyc != F4) begin
            errors++;
            $display("FAIL single_stream: got %b n=%0d done@%0d want %b n=%0d done@%0d",
                     s, n, done_cyc, S_1011, F4, F4);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = '0;
        int n = 0, d1 = -1, d2 = -1;
        for (int i = 0; i < 2 * F4 + 3; i++) begin
            drive(1'b0, i <= F4, (i == 0) ? 4'b1011 : 4'b0110, 1'b0, 8'h00);
            checks++;
            if ({sv4, so4, dn4, rdy4} !== exp4()) begin
                errors++;
                $display("FAIL b2b cyc%0d: got %b want %b", i + 1, {sv4, so4, dn4, rdy4}, exp4());
            end
            if (sv4) begin s = {s[14:0], so4}; n++; end
            if (dn4) begin
                if (d1 < 0) d1 = i + 1; else d2 = i + 1;
            end
        end
        checks++;
        if (s !== S_B2B || n != 2 * F4 || d1 != F4 || d2 != 2 * F4) begin
            errors++;
            $display("FAIL b2b_stream: got %b n=%0d done@%0d,%0d want %b n=%0d done@%0d,%0d",
                     s, n, d1, d2, S_B2B, 2 * F4, F4, 2 * F4);
        end
    endtask

    task automatic test_ignore_midframe();
        logic [15:0] s = '0;
        int n = 0;
        for (int i = 0; i < F4 + 4; i++) begin
            drive(1'b0, i == 0 || i == 2, (i == 0) ? 4'b1011 : 4'b1111, 1'b0, 8'h00);
            checks++;
            if ({sv4, so4, dn4, rdy4} !== exp4()) begin
                errors++;
                $display("FAIL ignore cyc%0d: got %b want %b", i + 1, {sv4, so4, dn4, rdy4}, exp4());
            end
            if (sv4) begin s = {s[14:0], so4}; n++; end
        end
        checks++;
        if (s !== S_1011 || n != F4) begin
            errors++;
            $display("FAIL ignore_stream: got %b n=%0d want %b n=%0d", s, n, S_1011, F4);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] s = '0;
        int n = 0, dn_seen = 0;
        drive(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 4'b0000, 1'b0, 8'h00);
        checks++;
        if ({sv4, so4, dn4, rdy4} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid: got %b want 0001", {sv4, so4, dn4, rdy4});
        end
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00);
        if (dn4) dn_seen++;
        for (int i = 0; i < F4 + 2; i++) begin
            drive(1'b0, i == 0, 4'b0001, 1'b0, 8'h00);
            checks++;
            if ({sv4, so4, dn4, rdy4} !== exp4()) begin
                errors++;
                $display("FAIL rst_reload cyc%0d: got %b want %b", i + 1, {sv4, so4, dn4, rdy4}, exp4());
            end
            if (sv4) begin s = {s[14:0], so4}; n++; end
        end
        checks++;
        if (s !== S_0001 || n != F4 || dn_seen != 0) begin
            errors++;
            $display("FAIL rst_reload_stream: got %b n=%0d stray_done=%0d want %b n=%0d",
                     s, n, dn_seen, S_0001, F4);
        end
    endtask

    task automatic test_width8();
        logic [15:0] s = '0;
        int n = 0, done_cyc = -1;
        for (int i = 0; i < F8 + 3; i++) begin
            drive(1'b0, 1'b0, 4'b0000, i == 0, 8'hA5);
            checks++;
            if ({sv8, so8, dn8, rdy8} !== exp8()) begin
                errors++;
                $display("FAIL w8 cyc%0d: got %b want %b", i + 1, {sv8, so8, dn8, rdy8}, exp8());
            end
            if (sv8) begin s = {s[14:0], so8}; n++; end
            if (dn8) done_cyc = i + 1;
        end
        checks++;
        if (s !== S_A5 || n != F8 || done_cyc != F8) begin
            errors++;
            $display("FAIL w8_stream: got %b n=%0d done@%0d want %b n=%0d done@%0d",
                     s, n, done_cyc, S_A5, F8, F8);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, 4'($urandom),
                  $urandom_range(0, 2) != 0, 8'($urandom));
            checks++;
            if ({sv4, so4, dn4, rdy4} !== exp4()) begin
                errors++;
                $display("FAIL rand_w4 cyc%0d: got %b want %b", i, {sv4, so4, dn4, rdy4}, exp4());
            end
            checks++;
            if ({sv8, so8, dn8, rdy8} !== exp8()) begin
                errors++;
                $display("FAIL rand_w8 cyc%0d: got %b want %b", i, {sv8, so8, dn8, rdy8}, exp8());
            end
        end
        for (int i = 0; i < F8 + 1; i++) drive(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_width8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
